// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and a one-hot helper for the 8-way
// round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arbState_t;

  function automatic logic [N_REQ-1:0] oneHot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] vec;
    vec = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: the first active request strictly after
// lastIdx, wrapping, with lastIdx itself checked last.
module rr_pick8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] win_idx,
  output logic             any
);

  logic [IDX_W-1:0] offset;
  logic [N_REQ-1:0] rotReq;
  logic [IDX_W-1:0] rotIdx;

  assign offset = last_idx + IDX_W'(1);

  // Rotate right so that requester lastIdx+1 lands at position 0.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : gRot
    assign rotReq[gi] = req[IDX_W'(gi) + offset];
  end

  always_comb begin
    rotIdx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rotReq[i]) rotIdx = IDX_W'(i);
    end
  end

  // 3-bit addition wraps mod 8, undoing the rotation.
  assign win_idx = rotIdx + offset;
  assign any     = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters: grants are held until done, owner
// release or MAX_HOLD, and every release is followed by one idle cycle.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_valid,
  output logic             timeout
);

  arbState_t        state;
  logic [CNT_W-1:0] holdCnt;
  logic [IDX_W-1:0] lastIdx;
  logic [IDX_W-1:0] pickIdx;
  logic             pickAny;
  logic             ownerReq;
  logic             limitHit;
  logic             releaseNow;

  rr_pick8 uPick (
    .req      (req),
    .last_idx (lastIdx),
    .win_idx  (pickIdx),
    .any      (pickAny)
  );

  assign ownerReq   = req[grant_idx];
  assign limitHit   = (holdCnt == CNT_W'(MAX_HOLD - 1));
  assign releaseNow = done || !ownerReq || limitHit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      timeout     <= 1'b0;
      holdCnt     <= '0;
      lastIdx     <= IDX_W'(N_REQ - 1);
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pickAny) begin
            state       <= GRANT;
            grant       <= oneHot(pickIdx);
            grant_idx   <= pickIdx;
            grant_valid <= 1'b1;
            lastIdx     <= pickIdx;
            holdCnt     <= '0;
          end
        end
        GRANT: begin
          if (releaseNow) begin
            state       <= IDLE;
            grant       <= '0;
            grant_idx   <= '0;
            grant_valid <= 1'b0;
            holdCnt     <= '0;
            // Flag only releases forced purely by the hold limit.
            timeout     <= limitHit && !done && ownerReq;
          end else begin
            holdCnt <= holdCnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       timeout;

  typedef struct packed {
    logic [7:0] g;
    logic [2:0] i;
    logic       t;
  } exp_t;

  exp_t q[$];
  int   nCompared = 0;
  int   nMismatched = 0;
  int   stepNo = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("grant[%0d]", stepNo), grant, e.g);
      check($sformatf("grant_idx[%0d]", stepNo), {5'd0, grant_idx}, {5'd0, e.i});
      check($sformatf("grant_valid[%0d]", stepNo), {7'd0, grant_valid}, {7'd0, (e.g != 8'h00)});
      check($sformatf("timeout[%0d]", stepNo), {7'd0, timeout}, {7'd0, e.t});
      $display("step %0d: req=%h done=%b grant=%h idx=%0d valid=%b timeout=%b",
               stepNo, req, done, grant, grant_idx, grant_valid, timeout);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic step(input logic [7:0] r, input logic d,
                      input logic [7:0] eg, input logic [2:0] ei, input logic et);
    req  = r;
    done = d;
    stepNo++;
    q.push_back('{g: eg, i: ei, t: et});
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic checkIdleNow(input string name);
    check({name, " grant"}, grant, 8'h00);
    check({name, " grant_idx"}, {5'd0, grant_idx}, 8'h00);
    check({name, " grant_valid"}, {7'd0, grant_valid}, 8'h00);
    check({name, " timeout"}, {7'd0, timeout}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with everyone requesting.
    rst_n = 1'b0;
    req   = 8'hFF;
    repeat (2) @(negedge clk);
    #1;
    checkIdleNow("reset");
    rst_n = 1'b1;
    step(8'hFF, 1'b0, 8'h01, 3'd0, 1'b0);

    // Round robin with done every grant cycle: 1..7 then wrap to 0.
    for (int k = 1; k <= 8; k++) begin
      step(8'hFF, 1'b1, 8'h00, 3'd0, 1'b0);
      step(8'hFF, 1'b0, 8'(1) << (k % 8), 3'(k % 8), 1'b0);
    end
    step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Single requester 5: grant held 3 cycles, done, one idle, regrant.
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
    step(8'h20, 1'b1, 8'h00, 3'd0, 1'b0);
    step(8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Hold limit: exactly 16 grant cycles, timeout on release, regrant.
    step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
    for (int k = 0; k < 15; k++) step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
    step(8'h08, 1'b0, 8'h00, 3'd0, 1'b1);
    step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
    // Done coinciding with the limit: plain release, no timeout.
    for (int k = 0; k < 15; k++) step(8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
    step(8'h08, 1'b1, 8'h00, 3'd0, 1'b0);

    // Owner drop: 2 releases when req moves to 6; then non-owner ignored.
    step(8'h04, 1'b0, 8'h04, 3'd2, 1'b0);
    step(8'h40, 1'b0, 8'h00, 3'd0, 1'b0);
    step(8'h40, 1'b0, 8'h40, 3'd6, 1'b0);
    step(8'h41, 1'b0, 8'h40, 3'd6, 1'b0);
    step(8'h01, 1'b0, 8'h00, 3'd0, 1'b0);
    step(8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
    step(8'h00, 1'b0, 8'h00, 3'd0, 1'b0);

    // Reset mid-grant drops outputs before the next edge; last winner resets to 7.
    step(8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
    rst_n = 1'b0;
    #1;
    checkIdleNow("async reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step(8'h11, 1'b0, 8'h01, 3'd0, 1'b0);
    step(8'h11, 1'b1, 8'h00, 3'd0, 1'b0);
    step(8'h11, 1'b0, 8'h10, 3'd4, 1'b0);

    repeat (3) @(negedge clk);
    nCompared++;
    if (q.size() != 0) begin
      nMismatched++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
